// File: rtl/char_uart_streamer.sv
// -----------------------------------------------------------------------------
// char_uart_streamer
//
// Streams a fixed-length window of character bytes out of a UART line in
// 8N1 format. Each frame sends NUM_CHARS bytes from a snapshot of the
// character window. When TERMINATE is nonzero, CR (0x0D) and LF (0x0A) are
// appended. A 0x00 byte in the window is sent as a space (0x20). Consecutive
// characters are sent back to back, with no idle gap between them.
//
// A frame starts on an explicit send request. With auto_en set, a frame also
// starts whenever the character window differs from the last snapshot.
// A send request that arrives while a frame is running is remembered in a
// single pending flag. That flag is served immediately after the frame ends.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per UART bit (2..65535)
//   NUM_CHARS     character bytes per frame
//   TERMINATE     1: append CR LF after the characters, 0: append nothing
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   chars    character window, chars[0] is transmitted first
//   send     frame request, sampled every rising edge
//   auto_en  start a frame whenever chars differs from the last snapshot
//   tx       UART serial output, idle high
//   busy     high while a frame is being shifted out
//   done     one-cycle pulse in the cycle after the last stop bit
// -----------------------------------------------------------------------------
module char_uart_streamer #(
  parameter int CLKS_PER_BIT = 434,
  parameter int NUM_CHARS    = 18,
  parameter int TERMINATE    = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CHARS-1:0][7:0] chars,
  input  logic                      send,
  input  logic                      auto_en,
  output logic                      tx,
  output logic                      busy,
  output logic                      done
);

  // Bytes per frame: the characters plus the optional CR/LF pair.
  localparam int TOTAL_BYTES = NUM_CHARS + ((TERMINATE != 0) ? 2 : 0);
  // The byte index is wide enough to hold TOTAL_BYTES itself.
  // This keeps comparisons against NUM_CHARS free of truncation.
  localparam int IDX_W = $clog2(TOTAL_BYTES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL_BYTES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [15:0]      BIT_MAX  = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                      state_reg;
  logic [15:0]                 cnt_reg;    // cycles spent in the current bit
  logic [2:0]                  bit_reg;    // data bit being driven, LSB first
  logic [IDX_W-1:0]            idx_reg;    // byte position within the frame
  logic [NUM_CHARS-1:0][7:0]   snap_reg;   // the only source of transmitted data
  logic                        pend_reg;   // one remembered send request
  logic                        tx_reg;
  logic                        busy_reg;
  logic                        done_reg;

  // ---------------------------------------------------------------------------
  // Frame byte table, built from the snapshot.
  // Character slots substitute a space for NUL. The tail slots are the
  // fixed CR/LF terminator.
  // ---------------------------------------------------------------------------
  logic [7:0] frame_byte [TOTAL_BYTES];

  generate
    for (genvar gi = 0; gi < TOTAL_BYTES; gi++) begin : g_frame_byte
      if (gi < NUM_CHARS) begin : g_char
        assign frame_byte[gi] = (snap_reg[gi] == 8'h00) ? 8'h20 : snap_reg[gi];
      end else if (gi == NUM_CHARS) begin : g_cr
        assign frame_byte[gi] = 8'h0D;
      end else begin : g_lf
        assign frame_byte[gi] = 8'h0A;
      end
    end
  endgenerate

  // Byte currently being serialised, selected by the frame position.
  logic [7:0] cur_byte;

  always_comb begin
    cur_byte = 8'h20;
    for (int i = 0; i < TOTAL_BYTES; i++) begin
      if (idx_reg == IDX_W'(i)) begin
        cur_byte = frame_byte[i];
      end
    end
  end

  logic [2:0] bit_next;
  assign bit_next = bit_reg + 3'd1;

  // ---------------------------------------------------------------------------
  // Trigger evaluation.
  // A frame launches from IDLE on a fresh trigger. It also launches from DONE
  // on a fresh trigger or a pending request. Sending and auto-triggering in
  // the same cycle both feed one launch, so only one frame starts.
  // ---------------------------------------------------------------------------
  logic chars_differ;
  logic trigger;
  logic launch;

  assign chars_differ = (chars != snap_reg);
  assign trigger      = send | (auto_en & chars_differ);
  assign launch       = ((state_reg == IDLE) && trigger) ||
                        ((state_reg == DONE) && (trigger || pend_reg));

  // ---------------------------------------------------------------------------
  // Serialiser FSM. tx, busy and done are all registered, so the line level
  // changes together with the state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      idx_reg   <= '0;
      snap_reg  <= '0;
      pend_reg  <= 1'b0;
      tx_reg    <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;

      // Any number of requests during a frame collapse into one pending flag.
      if (send && busy_reg) begin
        pend_reg <= 1'b1;
      end

      if (launch) begin
        // The snapshot is taken on the launch edge. Later changes to chars
        // cannot leak into this frame.
        snap_reg  <= chars;
        state_reg <= START;
        cnt_reg   <= '0;
        bit_reg   <= '0;
        idx_reg   <= '0;
        pend_reg  <= 1'b0;
        tx_reg    <= 1'b0;
        busy_reg  <= 1'b1;
      end else begin
        case (state_reg)
          IDLE: begin
            tx_reg   <= 1'b1;
            busy_reg <= 1'b0;
          end

          START: begin
            if (cnt_reg == BIT_MAX) begin
              cnt_reg   <= '0;
              bit_reg   <= '0;
              tx_reg    <= cur_byte[0];
              state_reg <= DATA;
            end else begin
              cnt_reg <= cnt_reg + 16'd1;
            end
          end

          DATA: begin
            if (cnt_reg == BIT_MAX) begin
              cnt_reg <= '0;
              if (bit_reg == 3'd7) begin
                tx_reg    <= 1'b1;
                state_reg <= STOP;
              end else begin
                bit_reg <= bit_next;
                tx_reg  <= cur_byte[bit_next];
              end
            end else begin
              cnt_reg <= cnt_reg + 16'd1;
            end
          end

          STOP: begin
            if (cnt_reg == BIT_MAX) begin
              cnt_reg <= '0;
              if (idx_reg == LAST_IDX) begin
                // Last stop bit done.
                // The index is parked at 0 rather than advanced past the end.
                idx_reg   <= '0;
                tx_reg    <= 1'b1;
                busy_reg  <= 1'b0;
                done_reg  <= 1'b1;
                state_reg <= DONE;
              end else begin
                // The next start bit follows directly, with no idle gap.
                idx_reg   <= idx_reg + IDX_ONE;
                tx_reg    <= 1'b0;
                state_reg <= START;
              end
            end else begin
              cnt_reg <= cnt_reg + 16'd1;
            end
          end

          DONE: begin
            // No launch this cycle, so there is no pending request to keep.
            pend_reg  <= 1'b0;
            tx_reg    <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end

          default: begin
            tx_reg    <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

  assign tx   = tx_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: doc/char_uart_streamer.md
CHAR_UART_STREAMER -- requirements
Module: char_uart_streamer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (legal range 2..65535).
REQ-002 SHALL have parameter NUM_CHARS, default 18, number of character bytes per frame.
REQ-003 SHALL have parameter TERMINATE, default 1; 1 appends CR (0x0D) and LF (0x0A) after the characters, 0 appends nothing.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous reset, active-low.
REQ-006 chars  input  8 x [NUM_CHARS-1:0]  character bytes from the data memory's character window; index 0 is sent first.
REQ-007 send  input  1  request one frame; sampled every rising edge.
REQ-008 auto_en  input  1  when 1, start a frame whenever chars differs from the last-sent snapshot.
REQ-009 tx  output  1  UART serial line, 8N1, idle high.
REQ-010 busy  output  1  high while a frame is in progress.
REQ-011 done  output  1  one-cycle pulse when a frame completes.

Function
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP and DONE.
REQ-013 In IDLE, a trigger SHALL be send=1, or auto_en=1 with chars != last-sent snapshot.
- Next cycle: copy chars into an internal snapshot, enter START, set busy=1.
REQ-014 Snapshot SHALL be the only source of transmitted data; chars changes during a frame SHALL NOT alter that frame.
REQ-015 Byte 0x00 in the snapshot SHALL be transmitted as 0x20 (space); all other values SHALL be transmitted unchanged.
REQ-016 START SHALL drive tx=0 for exactly CLKS_PER_BIT cycles.
REQ-017 DATA SHALL drive 8 bits LSB first, each for exactly CLKS_PER_BIT cycles.
REQ-018 STOP SHALL drive tx=1 for exactly CLKS_PER_BIT cycles.
REQ-019 Character and bit sequencing:
- After STOP, if bytes remain (NUM_CHARS + 2*TERMINATE total), go to START with the next byte index.
- Otherwise go to DONE.
- No idle gap between characters.
REQ-020 DONE SHALL last one cycle with done=1 and busy=0, then return to IDLE.
REQ-021 Total frame length, first start-bit cycle to last stop-bit cycle, SHALL be (NUM_CHARS+2*TERMINATE)*10*CLKS_PER_BIT cycles.
REQ-022 send=1 while busy SHALL set a single pending flag; repeated requests SHALL NOT queue more than one.
REQ-023 The pending flag SHALL be consumed in the DONE cycle: the FSM SHALL enter START the next cycle with a fresh snapshot, and the flag SHALL clear.
REQ-024 If auto_en=1 and chars differs from the snapshot at the DONE cycle, a new frame SHALL start exactly as for a pending request.
REQ-025 send and auto-trigger in the same cycle SHALL start exactly one frame.
REQ-026 Bit-period counter and byte index SHALL reset to 0 at each bit and frame boundary respectively; no wrap beyond the last byte.
REQ-027 tx SHALL be 1 in IDLE and DONE.

Reset
REQ-028 rst_n=0 SHALL, asynchronously:
- set tx=1, busy=0, done=0;
- set the FSM to IDLE;
- clear the pending flag, counters and byte index;
- set the snapshot to all 0x00.
REQ-029 Reset asserted mid-frame SHALL abort immediately, with tx high at once and no partial-character completion.
REQ-030 After rst_n rises, the first trigger SHALL be evaluated on the first rising edge.
REQ-031 With auto_en=1 and nonzero chars after reset, the block SHALL start a frame, because the reset snapshot is all 0x00.

Verification (CLKS_PER_BIT=4, NUM_CHARS=18, TERMINATE=1)
REQ-032 Single frame:
- Stimulus: chars="HELLO" then 0x00s; one-cycle send pulse.
- Response: 0x48 0x45 0x4C 0x4C 0x4F, then 13 x 0x20, then 0x0D 0x0A.
- Frame of 800 cycles; single done pulse; busy low after.
REQ-033 Bit timing:
- Stimulus: send with chars[0]=0xA5.
- Response: start low 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop high 4 cycles.
REQ-034 Pending request:
- Stimulus: three send pulses during a frame.
- Response: exactly one extra frame, starting the cycle after done.
REQ-035 Snapshot isolation:
- Stimulus: change chars[17] from 0x41 to 0x42 at cycle 100 of a frame.
- Response: frame carries 0x41.
- With auto_en=1, a second frame follows carrying 0x42.
REQ-036 Reset mid-frame:
- Stimulus: rst_n low during a DATA bit.
- Response: tx=1 and busy=0 without waiting for a clock edge; after release, no transmission without a trigger.
REQ-037 Auto idle:
- Stimulus: auto_en=1 with chars held equal to the last-sent snapshot for 1000 cycles.
- Response: no frame; tx stays 1.
